din_serializer: RTL and testbench

//  Parallel-to-serial front end for the 3-state din-driven FSM: accepts WIDTH-bit

---
 rtl/din_serializer.sv | 184 ++++++++++++++++++
 tb/tb_din_serializer.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/din_serializer.sv
// Parallel-to-serial front end: a one-entry hold register feeds a shifter that drives ser_bit.
// Optional even-parity bit per word when DIN_SER_PARITY_EN is defined.
module din_serializer #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned GAP       = 0,
  parameter bit          MSB_FIRST = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  input  logic             stall,
  output logic             ser_bit,
  output logic             ser_valid,
  output logic             word_done
);

  localparam int unsigned CW        = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] BIT_LAST = CW'(WIDTH - 1);
  localparam logic [3:0]  GAP_LAST  = 4'(GAP - 1);
  localparam bit          HAS_GAP   = (GAP != 0);

`ifdef DIN_SER_PARITY_EN
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_SHIFT = 2'd1, S_GAP = 2'd2, S_PARITY = 2'd3} state_t;
`else
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_SHIFT = 2'd1, S_GAP = 2'd2} state_t;
`endif

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [WIDTH-1:0] hold_q, hold_d;
  logic             hold_full_q, hold_full_d;
  logic [CW-1:0]    bit_cnt_q, bit_cnt_d;
  logic [3:0]       gap_cnt_q, gap_cnt_d;
  logic             in_ready_q, in_ready_d;
  logic             ser_bit_q, ser_bit_d;
  logic             ser_valid_q, ser_valid_d;
  logic             word_done_q, word_done_d;
`ifdef DIN_SER_PARITY_EN
  logic             parity_q, parity_d;
`endif

  logic [WIDTH-1:0] shifted_c;
  logic             load_c;
  logic             word_end_c;
  logic             go_next_c;

  // Bit that appears on the line first for a given shifter image.
  function automatic logic line_bit(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? w[WIDTH-1] : w[0];
  endfunction

  assign shifted_c = MSB_FIRST ? {shreg_q[WIDTH-2:0], 1'b0} : {1'b0, shreg_q[WIDTH-1:1]};

  always_comb begin
    state_d     = state_q;
    shreg_d     = shreg_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    bit_cnt_d   = bit_cnt_q;
    gap_cnt_d   = gap_cnt_q;
    ser_bit_d   = ser_bit_q;
    ser_valid_d = ser_valid_q;
    word_done_d = 1'b0;
    load_c      = 1'b0;
    word_end_c  = 1'b0;
    go_next_c   = 1'b0;
`ifdef DIN_SER_PARITY_EN
    parity_d    = parity_q;
`endif

    if (!stall) begin
      case (state_q)
        S_IDLE: begin
          if (hold_full_q) load_c = 1'b1;
        end
        S_SHIFT: begin
          if (bit_cnt_q == BIT_LAST) begin
`ifdef DIN_SER_PARITY_EN
            state_d     = S_PARITY;
            ser_bit_d   = parity_q;
            ser_valid_d = 1'b1;
`else
            word_end_c  = 1'b1;
`endif
          end else begin
            bit_cnt_d = bit_cnt_q + CW'(1);
            shreg_d   = shifted_c;
            ser_bit_d = line_bit(shifted_c);
          end
        end
`ifdef DIN_SER_PARITY_EN
        S_PARITY: word_end_c = 1'b1;
`endif
        S_GAP: begin
          if (gap_cnt_q == GAP_LAST) go_next_c = 1'b1;
          else                       gap_cnt_d = gap_cnt_q + 4'd1;
        end
        default: state_d = S_IDLE;
      endcase

      // Word finished on the line: pulse done, then idle gap or straight to next word.
      if (word_end_c) begin
        word_done_d = 1'b1;
        if (HAS_GAP) begin
          state_d     = S_GAP;
          gap_cnt_d   = 4'd0;
          ser_bit_d   = 1'b0;
          ser_valid_d = 1'b0;
        end else begin
          go_next_c = 1'b1;
        end
      end

      if (go_next_c) begin
        if (hold_full_q) begin
          load_c = 1'b1;
        end else begin
          state_d     = S_IDLE;
          ser_bit_d   = 1'b0;
          ser_valid_d = 1'b0;
        end
      end

      if (load_c) begin
        state_d     = S_SHIFT;
        shreg_d     = hold_q;
        bit_cnt_d   = '0;
        ser_bit_d   = line_bit(hold_q);
        ser_valid_d = 1'b1;
        hold_full_d = 1'b0;
`ifdef DIN_SER_PARITY_EN
        parity_d    = ^hold_q;
`endif
      end
    end

    // Accept only into an empty hold; a load needs a full hold, so the two never collide.
    if (in_valid && !hold_full_q) begin
      hold_d      = in_data;
      hold_full_d = 1'b1;
    end
    in_ready_d = !hold_full_d;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      shreg_q     <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      bit_cnt_q   <= '0;
      gap_cnt_q   <= 4'd0;
      in_ready_q  <= 1'b1;
      ser_bit_q   <= 1'b0;
      ser_valid_q <= 1'b0;
      word_done_q <= 1'b0;
`ifdef DIN_SER_PARITY_EN
      parity_q    <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      shreg_q     <= shreg_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      bit_cnt_q   <= bit_cnt_d;
      gap_cnt_q   <= gap_cnt_d;
      in_ready_q  <= in_ready_d;
      ser_bit_q   <= ser_bit_d;
      ser_valid_q <= ser_valid_d;
      word_done_q <= word_done_d;
`ifdef DIN_SER_PARITY_EN
      parity_q    <= parity_d;
`endif
    end
  end

  assign in_ready  = in_ready_q;
  assign ser_bit   = ser_bit_q;
  assign ser_valid = ser_valid_q;
  assign word_done = word_done_q;

endmodule

// File: tb/tb_din_serializer.sv
// Directed bench for din_serializer: instance a (GAP=0, LSB first), instance b (GAP=3, MSB first).
// Expected line length follows DIN_SER_PARITY_EN.
module tb_din_serializer;

`ifdef DIN_SER_PARITY_EN
  localparam int W_LEN = 9;
`else
  localparam int W_LEN = 8;
`endif

  logic       clk;
  logic       rst;
  logic       stall;
  logic       in_valid_a, in_valid_b;
  logic [7:0] in_data_a, in_data_b;
  logic       in_ready_a, in_ready_b;
  logic       ser_bit_a, ser_bit_b;
  logic       ser_valid_a, ser_valid_b;
  logic       word_done_a, word_done_b;

  int   errors = 0;
  int   checks = 0;
  int   vcount = 0;
  logic rdy_at1;

  din_serializer #(.WIDTH(8), .GAP(0), .MSB_FIRST(1'b0)) u_a (
    .clk(clk), .rst(rst), .in_valid(in_valid_a), .in_data(in_data_a), .in_ready(in_ready_a),
    .stall(stall), .ser_bit(ser_bit_a), .ser_valid(ser_valid_a), .word_done(word_done_a));

  din_serializer #(.WIDTH(8), .GAP(3), .MSB_FIRST(1'b1)) u_b (
    .clk(clk), .rst(rst), .in_valid(in_valid_b), .in_data(in_data_b), .in_ready(in_ready_b),
    .stall(stall), .ser_bit(ser_bit_b), .ser_valid(ser_valid_b), .word_done(word_done_b));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic o_valid(input bit sel);
    return sel ? ser_valid_b : ser_valid_a;
  endfunction
  function automatic logic o_bit(input bit sel);
    return sel ? ser_bit_b : ser_bit_a;
  endfunction
  function automatic logic o_done(input bit sel);
    return sel ? word_done_b : word_done_a;
  endfunction

  // Called in the cycle the first bit is on the line; returns in the cycle after the last bit.
  task automatic expect_word(input bit sel, input bit msb, input logic [7:0] w, input string tag,
                             input int stall_at, input int stall_len);
    logic exp_b;
    vcount = 0;
    for (int i = 0; i < W_LEN; i++) begin
      if (i >= 8)   exp_b = ^w;
      else if (msb) exp_b = w[7-i];
      else          exp_b = w[i];
      chk($sformatf("%s valid[%0d]", tag, i), o_valid(sel), 1);
      chk($sformatf("%s bit[%0d]", tag, i), o_bit(sel), exp_b);
      if (i > 0) chk($sformatf("%s done[%0d]", tag, i), o_done(sel), 0);
      vcount++;
      if (i == stall_at) begin
        stall = 1'b1;
        for (int k = 0; k < stall_len; k++) begin
          step();
          chk($sformatf("%s stall bit[%0d]", tag, k), o_bit(sel), exp_b);
          chk($sformatf("%s stall valid[%0d]", tag, k), o_valid(sel), 1);
          chk($sformatf("%s stall done[%0d]", tag, k), o_done(sel), 0);
          vcount++;
        end
        stall = 1'b0;
      end
      step();
      if (i == 0) begin
        rdy_at1    = sel ? in_ready_b : in_ready_a;
        in_valid_a = 1'b0;
        in_valid_b = 1'b0;
      end
    end
  endtask

  initial begin
    rst = 1'b0; stall = 1'b0;
    in_valid_a = 1'b0; in_valid_b = 1'b0;
    in_data_a = 8'h00; in_data_b = 8'h00;
    rdy_at1 = 1'b1;
    step(); step();

    // Reset state
    chk("rst in_ready", in_ready_a, 1);
    chk("rst ser_valid", ser_valid_a, 0);
    chk("rst ser_bit", ser_bit_a, 0);
    chk("rst word_done", word_done_a, 0);
    chk("rst b in_ready", in_ready_b, 1);
    rst = 1'b1;
    step();
    chk("idle ser_valid", ser_valid_a, 0);

    // Test 1: single word 0xA5, LSB first
    in_valid_a = 1'b1; in_data_a = 8'hA5;
    step();
    chk("t1 in_ready after accept", in_ready_a, 0);
    chk("t1 valid before load", ser_valid_a, 0);
    in_valid_a = 1'b0;
    step();
    expect_word(1'b0, 1'b0, 8'hA5, "t1", -1, 0);
    chk("t1 word_done", word_done_a, 1);
    chk("t1 idle valid", ser_valid_a, 0);
    chk("t1 idle bit", ser_bit_a, 0);
    chk("t1 in_ready", in_ready_a, 1);
    step();
    chk("t1 done pulse end", word_done_a, 0);
    chk("t1 still idle", ser_valid_a, 0);

    // Test 2: 0x01 then 0x80 back-to-back
    in_valid_a = 1'b1; in_data_a = 8'h01;
    step();
    chk("t2 in_ready drop", in_ready_a, 0);
    in_data_a = 8'h80;
    step();
    chk("t2 in_ready after load", in_ready_a, 1);
    expect_word(1'b0, 1'b0, 8'h01, "t2w0", -1, 0);
    chk("t2 in_ready held word", rdy_at1, 0);
    chk("t2 done0", word_done_a, 1);
    expect_word(1'b0, 1'b0, 8'h80, "t2w1", -1, 0);
    chk("t2 done1", word_done_a, 1);
    chk("t2 end valid", ser_valid_a, 0);
    step();
    chk("t2 done1 end", word_done_a, 0);

    // Test 4: stall 4 cycles during bit 3 of 0xF0
    in_valid_a = 1'b1; in_data_a = 8'hF0;
    step();
    in_valid_a = 1'b0;
    step();
    expect_word(1'b0, 1'b0, 8'hF0, "t4", 3, 4);
    chk("t4 valid cycles", vcount, W_LEN + 4);
    chk("t4 done", word_done_a, 1);
    step();

    // Test 3: GAP=3, MSB first, 0xC0 twice
    in_valid_b = 1'b1; in_data_b = 8'hC0;
    step();
    chk("t3 in_ready drop", in_ready_b, 0);
    step();
    expect_word(1'b1, 1'b1, 8'hC0, "t3w0", -1, 0);
    chk("t3 done0", word_done_b, 1);
    chk("t3 gap1 valid", ser_valid_b, 0);
    chk("t3 gap1 bit", ser_bit_b, 0);
    step();
    chk("t3 gap2 valid", ser_valid_b, 0);
    chk("t3 gap2 done", word_done_b, 0);
    step();
    chk("t3 gap3 valid", ser_valid_b, 0);
    chk("t3 gap3 bit", ser_bit_b, 0);
    step();
    expect_word(1'b1, 1'b1, 8'hC0, "t3w1", -1, 0);
    chk("t3 done1", word_done_b, 1);
    chk("t3 end valid", ser_valid_b, 0);
    step(); step(); step(); step();
    chk("t3 idle after gap", ser_valid_b, 0);

    // Test 6: parity vectors (plain words when parity is off)
    in_valid_a = 1'b1; in_data_a = 8'h07;
    step();
    in_valid_a = 1'b0;
    step();
    expect_word(1'b0, 1'b0, 8'h07, "t6a", -1, 0);
    chk("t6a done", word_done_a, 1);
    step();
    in_valid_a = 1'b1; in_data_a = 8'h03;
    step();
    in_valid_a = 1'b0;
    step();
    expect_word(1'b0, 1'b0, 8'h03, "t6b", -1, 0);
    chk("t6b done", word_done_a, 1);
    step();

    // Test 5: async reset mid-word with a full hold
    in_valid_a = 1'b1; in_data_a = 8'hFF;
    step();
    in_data_a = 8'hAA;
    step();
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("t5 bit[%0d]", i), ser_bit_a, 1);
      chk($sformatf("t5 valid[%0d]", i), ser_valid_a, 1);
      step();
      if (i == 0) in_valid_a = 1'b0;
    end
    chk("t5 hold full", in_ready_a, 0);
    rst = 1'b0;
    #1;
    chk("t5 rst valid", ser_valid_a, 0);
    chk("t5 rst bit", ser_bit_a, 0);
    chk("t5 rst done", word_done_a, 0);
    chk("t5 rst in_ready", in_ready_a, 1);
    step();
    chk("t5 rst hold valid", ser_valid_a, 0);
    rst = 1'b1;
    for (int i = 0; i < 12; i++) begin
      step();
      chk($sformatf("t5 discarded valid[%0d]", i), ser_valid_a, 0);
      chk($sformatf("t5 discarded done[%0d]", i), word_done_a, 0);
    end
    chk("t5 in_ready after", in_ready_a, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
